mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have these ports (name direction width meaning):
  clk     in  1   single clock, rising edge
  rst_n   in  1   asynchronous active-low reset
  start   in  1   issue MULT/MULTU/DIV/DIVU, sampled on rising edge
  op      in  2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU (valid with start)
  a       in  32  rs operand (same EX operand bus that feeds the ALU)
  b       in  32  rt operand
  mthi    in  1   write wdata to HI
  mtlo    in  1   write wdata to LO
  wdata   in  32  MTHI/MTLO data
  flush   in  1   abort in-flight operation (EX-stage squash)
  busy    out 1   operation in flight; pipeline stalls on MFHI/MFLO/new start
  done    out 1   one-cycle pulse: HI/LO just updated by an operation
  hi      out 32  HI register (feeds EX result mux beside ALU y)
  lo      out 32  LO register
REQ-002 The reset SHALL be asynchronous, active-low on rst_n; single clock clk.

Function
REQ-003 The FSM SHALL have states IDLE, CALC, FIX; reset state IDLE.
REQ-004 In IDLE, start=1 SHALL latch op, a and b, clear the 6-bit counter, and move to CALC.
REQ-005 CALC SHALL run exactly 32 cycles: radix-2 shift-add for multiply, restoring shift-subtract for divide, on 32-bit magnitudes.
REQ-006 Signed ops SHALL take |a|, |b| at start; in FIX, product sign = a[31]^b[31], quotient sign = a[31]^b[31], remainder sign = a[31].
REQ-007 Multiply SHALL place the 64-bit product as HI=[63:32], LO=[31:0]; divide SHALL place remainder in HI and quotient in LO.
REQ-008 FIX SHALL last one cycle; on its exit edge HI/LO update, done=1 for exactly one cycle, state returns to IDLE.
REQ-009 busy SHALL be 1 in CALC and FIX (33 cycles per operation) and 0 in IDLE.
REQ-010 start while busy=1 SHALL be ignored (no queueing).
REQ-011 Divide by zero SHALL take full latency and yield HI=a (dividend as latched), LO=32'hFFFFFFFF.
REQ-012 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0 (no trap).
REQ-013 mthi/mtlo in IDLE SHALL write wdata to HI/LO on that edge; while busy they SHALL be ignored.
REQ-014 start and mthi/mtlo asserted together in IDLE: start SHALL win, move write dropped.
REQ-015 flush SHALL force IDLE on the next edge from any state; HI/LO unchanged, done not asserted; flush has priority over start in the same cycle.
REQ-016 hi and lo SHALL be direct register outputs (no combinational path from inputs).

Reset
REQ-017 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal operand/accumulator registers 0.
REQ-018 Reset asserted mid-operation SHALL discard the operation with no HI/LO update and no done pulse after release.

Structure
REQ-019 A shared package SHALL hold the op encoding constants (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU) and the FSM state encoding.
REQ-020 The design SHALL be one module; no sub-modules; sign fix-up done in FIX with one shared 32-bit negator pair.

Verification
REQ-021 MULT a=0xFFFFFFFF b=2 -> after 33 busy cycles done=1, HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-022 DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7 b=0 -> HI=7, LO=0xFFFFFFFF.
REQ-023 DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-024 MTHI wdata=0x12345678 in IDLE -> hi=0x12345678 next cycle; MTLO during busy -> lo unchanged after done.
REQ-025 MULTU 3*5 then flush on 10th CALC cycle -> busy=0 next cycle, no done pulse, HI/LO keep prior values; second start during busy ignored.
REQ-026 rst_n low on 20th CALC cycle -> all outputs 0 immediately, no done after release; next start completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit:
// operation encodings and FSM state encoding.
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers.
// 32 shift-add / restoring shift-subtract cycles plus one sign fix-up cycle.
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t      state;
    state_t      state_nx;
    logic        load;
    logic        step;
    logic        fix;

    logic [5:0]  cnt;
    logic        div_q;
    logic        neg_p;
    logic        neg_r;
    logic [31:0] opnd;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;

    logic        is_signed;
    logic        is_div;
    logic        sa;
    logic        sb;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    logic [31:0] nin_hi;
    logic [31:0] nin_lo;
    logic        hi_cin;
    logic [31:0] neg_hi;
    logic [31:0] neg_lo;

    logic [32:0] add_sum;
    logic [32:0] shl;
    logic [32:0] sub_diff;

    assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign is_div    = (op == MDU_DIV) || (op == MDU_DIVU);
    assign sa        = is_signed & a[31];
    assign sb        = is_signed & b[31];

    // One negator pair: takes |a|,|b| in IDLE, applies result sign in FIX.
    // For a 64-bit product the high half gets the borrow of the low half.
    assign nin_hi = (state == FIX) ? acc_hi : a;
    assign nin_lo = (state == FIX) ? acc_lo : b;
    assign hi_cin = (state == FIX) ? (div_q | (acc_lo == 32'd0)) : 1'b1;
    assign neg_hi = ~nin_hi + {31'd0, hi_cin};
    assign neg_lo = ~nin_lo + 32'd1;

    assign abs_a = sa ? neg_hi : a;
    assign abs_b = sb ? neg_lo : b;

    assign add_sum  = {1'b0, acc_hi} + {1'b0, opnd};
    assign shl      = {acc_hi, acc_lo[31]};
    assign sub_diff = shl - {1'b0, opnd};

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        fix      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CALC;
                    load     = 1'b1;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == 6'd31) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                fix      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            state_nx = IDLE;
            load     = 1'b0;
            step     = 1'b0;
            fix      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 6'd0;
            div_q  <= 1'b0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            opnd   <= 32'd0;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            done   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            done <= 1'b0;
            if (load) begin
                cnt    <= 6'd0;
                div_q  <= is_div;
                neg_p  <= sa ^ sb;
                neg_r  <= sa;
                acc_hi <= 32'd0;
                opnd   <= is_div ? abs_b : abs_a;
                acc_lo <= is_div ? abs_a : abs_b;
            end else if (step) begin
                cnt <= cnt + 6'd1;
                if (div_q) begin
                    if (!sub_diff[32]) begin
                        acc_hi <= sub_diff[31:0];
                        acc_lo <= {acc_lo[30:0], 1'b1};
                    end else begin
                        acc_hi <= shl[31:0];
                        acc_lo <= {acc_lo[30:0], 1'b0};
                    end
                end else if (acc_lo[0]) begin
                    acc_hi <= add_sum[32:1];
                    acc_lo <= {add_sum[0], acc_lo[31:1]};
                end else begin
                    acc_hi <= {1'b0, acc_hi[31:1]};
                    acc_lo <= {acc_hi[0], acc_lo[31:1]};
                end
            end else if (fix) begin
                done <= 1'b1;
                if (div_q) begin
                    hi <= neg_r ? neg_hi : acc_hi;
                    // Zero divisor reports an all-ones quotient regardless of sign.
                    if (opnd == 32'd0) begin
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        lo <= neg_p ? neg_lo : acc_lo;
                    end
                end else begin
                    hi <= neg_p ? neg_hi : acc_hi;
                    lo <= neg_p ? neg_lo : acc_lo;
                end
            end else if (state == IDLE && !start) begin
                if (mthi) begin
                    hi <= wdata;
                end
                if (mtlo) begin
                    lo <= wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO,
// a negedge monitor pops and compares on every done pulse.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          fails  = 0;
    logic [63:0] sb_q[$];
    logic [63:0] mon_e;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    mdu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL spurious_done hi=%h lo=%h expected no done",
                         hi, lo);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_hi", hi, mon_e[63:32]);
                check("done_lo", lo, mon_e[31:0]);
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (busy) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout busy=%b expected 0", name, busy);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] e,
                          input bit mt_busy);
        int n;
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        sb_q.push_back(e);
        cur_hi = e[63:32];
        cur_lo = e[31:0];
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (mt_busy) begin
                mtlo  = (n == 5);
                wdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
        end
        mtlo = 1'b0;
        check("latency", 32'(n), 32'd33);
    endtask

    task automatic mt_write(input bit to_hi, input logic [31:0] d);
        @(negedge clk);
        mthi  = to_hi;
        mtlo  = !to_hi;
        wdata = d;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        if (to_hi) begin
            cur_hi = d;
            check("mthi", hi, d);
        end else begin
            cur_lo = d;
            check("mtlo", lo, d);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog busy=%b expected run to finish", busy);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = MDU_MULT;
        a     = 32'd0;
        b     = 32'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = 32'd0;
        flush = 1'b0;
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst_n = 1'b1;

        mt_write(1'b1, 32'h1234_5678);
        mt_write(1'b0, 32'hCAFE_F00D);

        run_op(MDU_MULT,  32'hFFFF_FFFF, 32'd2,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2,
               64'h0000_0001_FFFF_FFFE, 1'b0);
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op(MDU_DIVU,  32'd7, 32'd0,
               64'h0000_0007_FFFF_FFFF, 1'b0);
        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF,
               64'h0000_0000_8000_0000, 1'b0);
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd0,
               64'hFFFF_FFF9_FFFF_FFFF, 1'b0);
        run_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_0000_0000, 1'b0);
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op(MDU_DIVU,  32'd100, 32'd7,
               64'h0000_0002_0000_000E, 1'b0);
        run_op(MDU_DIV,   32'd7, 32'hFFFF_FFFE,
               64'h0000_0001_FFFF_FFFD, 1'b0);
        run_op(MDU_MULTU, 32'd3, 32'd5,
               64'h0000_0000_0000_000F, 1'b1);

        // start together with mthi: the move is dropped
        mt_write(1'b1, 32'h0BAD_0BAD);
        @(negedge clk);
        op    = MDU_MULTU;
        a     = 32'd6;
        b     = 32'd7;
        start = 1'b1;
        mthi  = 1'b1;
        wdata = 32'h5555_5555;
        sb_q.push_back(64'h0000_0000_0000_002A);
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        check("start_beats_mthi", hi, cur_hi);
        wait_idle("start_mthi");
        cur_hi = 32'd0;
        cur_lo = 32'd42;

        // flush on 10th CALC cycle, with an ignored start in between
        @(negedge clk);
        op    = MDU_MULTU;
        a     = 32'd3;
        b     = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (k == 3) begin
                start = 1'b1;
                op    = MDU_DIVU;
                a     = 32'd99;
                b     = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_hi", hi, cur_hi);
        check("flush_lo", lo, cur_lo);
        repeat (40) @(negedge clk);
        check("flush_stays_idle", {31'd0, busy}, 32'd0);
        check("flush_hi_kept", hi, cur_hi);

        // reset on 20th CALC cycle
        mt_write(1'b1, 32'hA5A5_A5A5);
        @(negedge clk);
        op    = MDU_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
        end
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_lo", lo, 32'd0);
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_lo", lo, 32'd0);

        run_op(MDU_MULTU, 32'd3, 32'd5,
               64'h0000_0000_0000_000F, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
